// File: rtl/tri_solve.sv
// Complex fixed-point triangular solver: forward substitution with unit-lower L,
// or backward substitution with U whose diagonal slots hold reciprocal pivots.
module tri_solve #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start,
    input  logic                        mode_i,
    input  logic [SIZE*2*WIDTH-1:0]     b_i,
    output logic [$clog2(SIZE)-1:0]     mat_row_read_addr_o,
    output logic                        mat_row_read_addr_valid_o,
    input  logic [SIZE*2*WIDTH-1:0]     mat_row_i,
    input  logic                        mat_row_valid_i,
    input  logic [$clog2(SIZE)-1:0]     mat_row_read_addr_i,
    output logic [2*WIDTH-1:0]          result_o,
    output logic [$clog2(SIZE)-1:0]     result_addr_o,
    output logic                        result_valid_o,
    input  logic                        result_out_ready_i,
    input  logic                        flush_i,
    output logic                        in_ready_o,
    output logic                        busy_o
);

    localparam int AW   = $clog2(SIZE);
    localparam int CW   = 2 * WIDTH;
    localparam int PW   = 2 * WIDTH;
    localparam int ACCW = 2 * WIDTH + AW + 1;
    localparam int XW   = ACCW + 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

    localparam logic signed [XW-1:0] SAT_HI = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_LO = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        MAC,
        FIN,
        SCALE,
        OUT
    } state_t;

    state_t state, next_state;

    logic                    mode_reg;
    logic [SIZE*CW-1:0]      b_reg;
    logic [SIZE*CW-1:0]      row_reg;
    logic [AW-1:0]           row_idx;
    logic [AW-1:0]           col_idx;
    logic signed [ACCW-1:0]  acc_re, acc_im;
    logic signed [WIDTH-1:0] t_re, t_im;
    logic signed [WIDTH-1:0] res_re, res_im;
    logic signed [WIDTH-1:0] x_re [SIZE];
    logic signed [WIDTH-1:0] x_im [SIZE];

    logic                    row_hit;
    logic                    zero_terms;
    logic                    mac_last;
    logic                    last_row;
    logic                    handshake;

    logic [AW-1:0]           op_idx;
    logic signed [WIDTH-1:0] op_a_re, op_a_im, op_x_re, op_x_im;
    logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;
    logic signed [ACCW-1:0]  prod_re, prod_im;
    logic signed [WIDTH-1:0] b_sel_re, b_sel_im;
    logic signed [WIDTH-1:0] fin_re, fin_im;
    logic signed [WIDTH-1:0] scl_re, scl_im;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_HI) begin
            return MAX_W;
        end else if (v < SAT_LO) begin
            return MIN_W;
        end else begin
            return v[WIDTH-1:0];
        end
    endfunction

    assign row_hit    = mat_row_valid_i && (mat_row_read_addr_i == row_idx);
    assign zero_terms = mode_reg ? (row_idx == LAST_IDX) : (row_idx == '0);
    assign mac_last   = mode_reg ? (col_idx == LAST_IDX) : (col_idx == row_idx - ONE_IDX);
    assign last_row   = mode_reg ? (row_idx == '0) : (row_idx == LAST_IDX);
    assign handshake  = (state == OUT) && result_out_ready_i;

    // The single complex multiplier serves both the MAC terms and the
    // reciprocal-diagonal scaling, which never happen in the same cycle.
    always_comb begin
        op_idx  = (state == SCALE) ? row_idx : col_idx;
        op_a_re = $signed(row_reg[int'(op_idx)*CW +: WIDTH]);
        op_a_im = $signed(row_reg[int'(op_idx)*CW + WIDTH +: WIDTH]);
        if (state == SCALE) begin
            op_x_re = t_re;
            op_x_im = t_im;
        end else begin
            op_x_re = x_re[col_idx];
            op_x_im = x_im[col_idx];
        end
    end

    assign p_rr    = PW'(op_a_re) * PW'(op_x_re);
    assign p_ii    = PW'(op_a_im) * PW'(op_x_im);
    assign p_ri    = PW'(op_a_re) * PW'(op_x_im);
    assign p_ir    = PW'(op_a_im) * PW'(op_x_re);
    assign prod_re = ACCW'(p_rr) - ACCW'(p_ii);
    assign prod_im = ACCW'(p_ri) + ACCW'(p_ir);

    assign b_sel_re = $signed(b_reg[int'(row_idx)*CW +: WIDTH]);
    assign b_sel_im = $signed(b_reg[int'(row_idx)*CW + WIDTH +: WIDTH]);
    assign fin_re   = sat(XW'(b_sel_re) - XW'(acc_re >>> FRAC));
    assign fin_im   = sat(XW'(b_sel_im) - XW'(acc_im >>> FRAC));
    assign scl_re   = sat(XW'(prod_re >>> FRAC));
    assign scl_im   = sat(XW'(prod_im >>> FRAC));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = READ;
                READ:    next_state = WAIT;
                WAIT:    if (row_hit) next_state = zero_terms ? FIN : MAC;
                MAC:     if (mac_last) next_state = FIN;
                FIN:     next_state = mode_reg ? SCALE : OUT;
                SCALE:   next_state = OUT;
                OUT:     if (result_out_ready_i) next_state = last_row ? IDLE : READ;
                default: next_state = IDLE;
            endcase
        end
    end

    // Flush only redirects the FSM; the solution register keeps its contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_reg <= 1'b0;
            b_reg    <= '0;
            row_reg  <= '0;
            row_idx  <= '0;
            col_idx  <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            t_re     <= '0;
            t_im     <= '0;
            res_re   <= '0;
            res_im   <= '0;
            for (int i = 0; i < SIZE; i++) begin
                x_re[i] <= '0;
                x_im[i] <= '0;
            end
        end else if (!flush_i) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        b_reg    <= b_i;
                        mode_reg <= mode_i;
                        row_idx  <= mode_i ? LAST_IDX : '0;
                    end
                end
                WAIT: begin
                    if (row_hit) begin
                        row_reg <= mat_row_i;
                        acc_re  <= '0;
                        acc_im  <= '0;
                        col_idx <= mode_reg ? row_idx + ONE_IDX : '0;
                    end
                end
                MAC: begin
                    acc_re  <= acc_re + prod_re;
                    acc_im  <= acc_im + prod_im;
                    col_idx <= col_idx + ONE_IDX;
                end
                FIN: begin
                    t_re <= fin_re;
                    t_im <= fin_im;
                    if (!mode_reg) begin
                        res_re <= fin_re;
                        res_im <= fin_im;
                    end
                end
                SCALE: begin
                    res_re <= scl_re;
                    res_im <= scl_im;
                end
                OUT: begin
                    x_re[row_idx] <= res_re;
                    x_im[row_idx] <= res_im;
                    if (handshake && !last_row) begin
                        row_idx <= mode_reg ? row_idx - ONE_IDX : row_idx + ONE_IDX;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mat_row_read_addr_o       = row_idx;
    assign mat_row_read_addr_valid_o = (state == READ);
    assign result_o                  = {res_im, res_re};
    assign result_addr_o             = row_idx;
    assign result_valid_o            = (state == OUT);
    assign in_ready_o                = (state == IDLE);
    assign busy_o                    = !in_ready_o;

endmodule

// File: tb/tb_tri_solve.sv
// Directed bench for tri_solve: forward/backward solves, complex and saturating
// arithmetic, backpressure, stale rows, flush and asynchronous reset.
module tb_tri_solve;

    localparam int SIZE = 4;
    localparam int W    = 32;
    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;

    logic                   clk_i;
    logic                   rst_ni;
    logic                   start;
    logic                   mode_i;
    logic [SIZE*2*W-1:0]    b_i;
    logic [1:0]             mat_row_read_addr_o;
    logic                   mat_row_read_addr_valid_o;
    logic [SIZE*2*W-1:0]    mat_row_i;
    logic                   mat_row_valid_i;
    logic [1:0]             mat_row_read_addr_i;
    logic [2*W-1:0]         result_o;
    logic [1:0]             result_addr_o;
    logic                   result_valid_o;
    logic                   result_out_ready_i;
    logic                   flush_i;
    logic                   in_ready_o;
    logic                   busy_o;

    logic [SIZE*2*W-1:0]    mem [SIZE];
    logic [63:0]            expX [SIZE];
    logic                   staleEn;
    logic                   pendValid;
    logic [1:0]             pendAddr;
    int                     cyc;
    int                     checkCount;
    int                     errorCount;

    tri_solve #(.SIZE(SIZE), .WIDTH(W), .FRAC(16)) dut (
        .clk_i                     (clk_i),
        .rst_ni                    (rst_ni),
        .start                     (start),
        .mode_i                    (mode_i),
        .b_i                       (b_i),
        .mat_row_read_addr_o       (mat_row_read_addr_o),
        .mat_row_read_addr_valid_o (mat_row_read_addr_valid_o),
        .mat_row_i                 (mat_row_i),
        .mat_row_valid_i           (mat_row_valid_i),
        .mat_row_read_addr_i       (mat_row_read_addr_i),
        .result_o                  (result_o),
        .result_addr_o             (result_addr_o),
        .result_valid_o            (result_valid_o),
        .result_out_ready_i        (result_out_ready_i),
        .flush_i                   (flush_i),
        .in_ready_o                (in_ready_o),
        .busy_o                    (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Row memory with one-cycle latency; in stale mode a wrong-index row is
    // returned first and the requested row one cycle later.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mat_row_valid_i     <= 1'b0;
            mat_row_i           <= '0;
            mat_row_read_addr_i <= '0;
            pendValid           <= 1'b0;
            pendAddr            <= '0;
        end else begin
            mat_row_valid_i <= 1'b0;
            if (mat_row_read_addr_valid_o) begin
                mat_row_valid_i <= 1'b1;
                if (staleEn) begin
                    mat_row_read_addr_i <= mat_row_read_addr_o ^ 2'b01;
                    mat_row_i           <= {4{32'h0003_0000, 32'h0005_0000}};
                    pendValid           <= 1'b1;
                    pendAddr            <= mat_row_read_addr_o;
                end else begin
                    mat_row_read_addr_i <= mat_row_read_addr_o;
                    mat_row_i           <= mem[mat_row_read_addr_o];
                end
            end else if (pendValid) begin
                mat_row_valid_i     <= 1'b1;
                mat_row_read_addr_i <= pendAddr;
                mat_row_i           <= mem[pendAddr];
                pendValid           <= 1'b0;
            end
        end
    end

    function automatic logic [63:0] cp(input logic [31:0] re, input logic [31:0] im);
        return {im, re};
    endfunction

    function automatic logic [255:0] bvec(input logic [63:0] e0, input logic [63:0] e1,
                                          input logic [63:0] e2, input logic [63:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Present a start request and return at the negedge after it is accepted.
    task automatic applyStimulus(input logic mode, input logic [255:0] b);
        @(negedge clk_i);
        mode_i = mode;
        b_i    = b;
        start  = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start = 1'b0;
    endtask

    task automatic runSolve(input string name, input logic mode, input logic [255:0] b,
                            input int expCycles, input int holdIdx);
        int startCyc;
        int lastCyc;
        int guard;
        logic [1:0] expAddr;
        applyStimulus(mode, b);
        startCyc = cyc;
        lastCyc  = cyc;
        for (int n = 0; n < SIZE; n++) begin
            guard = 0;
            while (!result_valid_o && guard < 100) begin
                @(negedge clk_i);
                guard++;
            end
            if (!result_valid_o) begin
                checkOutput({name, " timeout"}, 64'd0, 64'd1);
                break;
            end
            expAddr = mode ? 2'(SIZE - 1 - n) : 2'(n);
            if (n == holdIdx) begin
                result_out_ready_i = 1'b0;
                start  = 1'b1;
                mode_i = !mode;
                repeat (5) @(negedge clk_i);
                start = 1'b0;
                checkOutput({name, " stall valid"}, 64'(result_valid_o), 64'd1);
                checkOutput({name, " stall no read"}, 64'(mat_row_read_addr_valid_o), 64'd0);
                checkOutput({name, " stall value"}, result_o, expX[expAddr]);
                checkOutput({name, " stall addr"}, 64'(result_addr_o), 64'(expAddr));
                result_out_ready_i = 1'b1;
            end
            checkOutput({name, " addr"}, 64'(result_addr_o), 64'(expAddr));
            checkOutput({name, " value"}, result_o, expX[expAddr]);
            lastCyc = cyc;
            @(negedge clk_i);
        end
        checkOutput({name, " cycles"}, 64'(lastCyc + 1 - startCyc), 64'(expCycles));
        checkOutput({name, " idle after"}, 64'(in_ready_o), 64'd1);
    endtask

    task automatic loadForward();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                mem[r][c*64 +: 64] = (c < r) ? cp(ONE, 32'd0) : cp(32'h0001_2345, 32'h0000_0777);
    endtask

    task automatic loadBackward();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                mem[r][c*64 +: 64] = (c == r) ? cp(HALF, 32'd0) :
                                     (c > r)  ? 64'd0 : cp(32'h0004_0000, 32'h0002_0000);
    endtask

    task automatic loadSparse(input logic [63:0] l10);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                mem[r][c*64 +: 64] = (c == r) ? cp(32'h0009_0000, 32'd0) : 64'd0;
        mem[1][0 +: 64] = l10;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        checkCount         = 0;
        errorCount         = 0;
        cyc                = 0;
        staleEn            = 1'b0;
        start              = 1'b0;
        mode_i             = 1'b0;
        b_i                = '0;
        result_out_ready_i = 1'b1;
        flush_i            = 1'b0;
        rst_ni             = 1'b0;
        loadForward();
        repeat (3) @(negedge clk_i);

        checkOutput("reset read addr", 64'(mat_row_read_addr_o), 64'd0);
        checkOutput("reset read valid", 64'(mat_row_read_addr_valid_o), 64'd0);
        checkOutput("reset result", result_o, 64'd0);
        checkOutput("reset result addr", 64'(result_addr_o), 64'd0);
        checkOutput("reset result valid", 64'(result_valid_o), 64'd0);
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready_o), 64'd1);
        rst_ni = 1'b1;

        $display("[TB] forward unit-L solve");
        for (int i = 0; i < SIZE; i++) expX[i] = cp(ONE, 32'd0);
        runSolve("fwd", 1'b0, bvec(cp(32'h0001_0000, 0), cp(32'h0002_0000, 0),
                                   cp(32'h0003_0000, 0), cp(32'h0004_0000, 0)), 22, -1);

        $display("[TB] backward reciprocal-diagonal solve");
        loadBackward();
        expX[0] = cp(32'h0001_0000, 0);
        expX[1] = cp(32'h0002_0000, 0);
        expX[2] = cp(32'h0003_0000, 0);
        expX[3] = cp(32'h0004_0000, 0);
        runSolve("bwd", 1'b1, bvec(cp(32'h0002_0000, 0), cp(32'h0004_0000, 0),
                                   cp(32'h0006_0000, 0), cp(32'h0008_0000, 0)), 26, -1);

        $display("[TB] complex forward solve");
        loadSparse(cp(32'd0, ONE));
        expX[0] = cp(ONE, 32'd0);
        expX[1] = cp(32'd0, 32'hFFFF_0000);
        expX[2] = 64'd0;
        expX[3] = 64'd0;
        runSolve("cplx", 1'b0, bvec(cp(ONE, 0), 64'd0, 64'd0, 64'd0), 22, -1);

        $display("[TB] saturating forward solve");
        loadSparse(cp(32'hFFFF_0000, 32'd0));
        expX[0] = cp(32'h7FFF_FFFF, 32'd0);
        expX[1] = cp(32'h7FFF_FFFF, 32'd0);
        expX[2] = 64'd0;
        expX[3] = 64'd0;
        runSolve("sat", 1'b0, bvec(cp(32'h7FFF_FFFF, 0), cp(32'h7FFF_FFFF, 0), 64'd0, 64'd0), 22, -1);

        $display("[TB] backpressure with stale rows and ignored start");
        loadForward();
        for (int i = 0; i < SIZE; i++) expX[i] = cp(ONE, 32'd0);
        staleEn = 1'b1;
        runSolve("stall", 1'b0, bvec(cp(32'h0001_0000, 0), cp(32'h0002_0000, 0),
                                     cp(32'h0003_0000, 0), cp(32'h0004_0000, 0)), 31, 1);
        staleEn = 1'b0;

        $display("[TB] flush during row 2 accumulation");
        applyStimulus(1'b0, bvec(cp(32'h0001_0000, 0), cp(32'h0002_0000, 0),
                                 cp(32'h0003_0000, 0), cp(32'h0004_0000, 0)));
        guard = 0;
        while (!(mat_row_read_addr_valid_o && mat_row_read_addr_o == 2'd2) && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        checkOutput("flush reach row2", 64'(mat_row_read_addr_valid_o && mat_row_read_addr_o == 2'd2), 64'd1);
        repeat (2) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        checkOutput("flush in_ready", 64'(in_ready_o), 64'd1);
        checkOutput("flush busy", 64'(busy_o), 64'd0);
        checkOutput("flush result valid", 64'(result_valid_o), 64'd0);
        checkOutput("flush read valid", 64'(mat_row_read_addr_valid_o), 64'd0);

        loadBackward();
        expX[0] = cp(32'h0001_0000, 0);
        expX[1] = cp(32'h0002_0000, 0);
        expX[2] = cp(32'h0003_0000, 0);
        expX[3] = cp(32'h0004_0000, 0);
        runSolve("postflush", 1'b1, bvec(cp(32'h0002_0000, 0), cp(32'h0004_0000, 0),
                                         cp(32'h0006_0000, 0), cp(32'h0008_0000, 0)), 26, -1);

        $display("[TB] asynchronous reset mid-solve");
        loadForward();
        applyStimulus(1'b0, bvec(cp(32'h0001_0000, 0), cp(32'h0002_0000, 0),
                                 cp(32'h0003_0000, 0), cp(32'h0004_0000, 0)));
        repeat (3) @(negedge clk_i);
        checkOutput("pre-reset valid", 64'(result_valid_o), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("async reset busy", 64'(busy_o), 64'd0);
        checkOutput("async reset in_ready", 64'(in_ready_o), 64'd1);
        checkOutput("async reset valid", 64'(result_valid_o), 64'd0);
        checkOutput("async reset result", result_o, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/tri_solve.md
# tri_solve

Complex fixed-point triangular solver that consumes matrix rows from the same external row memory the LU engine writes back to. Given a unit-lower L (forward mode) or an upper U with reciprocal diagonals (backward mode) plus a right-hand side b, it produces x one element at a time over a result handshake. It is the parametrised next stage after LU factorisation, generalised in width, precision and direction, and it is the block that turns L/U rows into an actual linear-system solution.

## Interface
- SIZE, 4, matrix order (≥2)
- WIDTH, 32, signed bits per real/imag component
- FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC)
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start  in  1  begin solve; accepted only when in_ready_o=1
- mode_i  in  1  0=forward (unit L), 1=backward (U); sampled with start
- b_i  in  SIZE*2*WIDTH  right-hand side; element j at [j*2W +: 2W], packed {imag,real}; sampled with start
- mat_row_read_addr_o  out  $clog2(SIZE)  row index requested
- mat_row_read_addr_valid_o  out  1  single-cycle read strobe
- mat_row_i  in  SIZE*2*WIDTH  returned row, same packing as b_i
- mat_row_valid_i  in  1  returned row valid
- mat_row_read_addr_i  in  $clog2(SIZE)  echo of the row index being returned
- result_o  out  2*WIDTH  solved element {imag,real}
- result_addr_o  out  $clog2(SIZE)  index of result_o
- result_valid_o  out  1  result available
- result_out_ready_i  in  1  consumer accepts
- flush_i  in  1  synchronous abort
- in_ready_o  out  1  idle, start acceptable
- busy_o  out  1  solve in progress

## Operation
- FSM states: IDLE, READ, WAIT, MAC, FIN, SCALE, OUT.
- IDLE: in_ready_o=1. On start, capture b, mode and row index: 0 for forward, SIZE-1 for backward. Go to READ.
- READ: assert the read strobe for exactly one cycle with the current row index. Go to WAIT.
- WAIT: hold until mat_row_valid_i=1 with mat_row_read_addr_i equal to the current row index. Rows with a different index are ignored. Capture the row and go to MAC.
- MAC: one complex multiply-accumulate per cycle over the already-solved indices.
  - Forward row i: j=0..i-1.
  - Backward row i: j=i+1..SIZE-1.
  - With zero terms (first row processed), skip MAC and go directly to FIN.
- Arithmetic:
  - Products are full precision, 2*WIDTH bits per component.
  - The accumulator is 2*WIDTH+$clog2(SIZE)+1 bits, with no truncation during accumulation.
- FIN: t = sat_WIDTH(b_i − (acc >>> FRAC)), where >>> is arithmetic shift (floor).
  - Forward mode: x_i = t, go to OUT.
  - Backward mode: go to SCALE.
- SCALE: x_i = sat_WIDTH((t × r) >>> FRAC), where r is the diagonal slot of the row, which holds 1/U[i][i]. Diagonal slots in forward mode are ignored (L is implicitly unit). Go to OUT.
- OUT: write x_i into the internal solution register. Drive result_valid_o with result_o=x_i and result_addr_o=i.
  - On handshake, advance the row index (+1 forward, −1 backward) and go to READ.
  - After the last row, go to IDLE.
- sat_WIDTH clamps each component independently to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Entries of the returned row outside the triangle are don't-care and never used.

## Timing
- Reset values: mat_row_read_addr_o=0, mat_row_read_addr_valid_o=0, result_o=0, result_addr_o=0, result_valid_o=0, busy_o=0, in_ready_o=1.
- in_ready_o = (state==IDLE); busy_o = !in_ready_o.
- Per row, with 1-cycle memory latency and ready held high:
  - 4+k cycles (READ 1, WAIT 1, MAC k, FIN 1, OUT 1), where k = number of terms.
  - Backward adds 1 cycle (SCALE).
- Total from start accept to last result handshake:
  - Forward: 4·SIZE + SIZE(SIZE−1)/2.
  - Backward: 5·SIZE + SIZE(SIZE−1)/2.
  - SIZE=4: 22 and 26 cycles.
- Output stability: result_o and result_addr_o stay stable while result_valid_o=1 && !result_out_ready_i.
- start while busy is ignored.
- flush_i has priority over every other event. At the next edge: state=IDLE, all valids=0, in_ready_o=1. The solution register is not cleared.
- Asynchronous reset mid-solve aborts immediately to the reset values.

## Test plan
- Forward, SIZE=4, L with 1.0 in every strictly-lower slot, b=(1,2,3,4) real → x=(1,1,1,1). result_o=0x00000000_00010000 for each, addrs 0,1,2,3, completing in 22 cycles.
- Backward, U=diag(2) with 0.5 stored on the diagonal and zeros above, b=(2,4,6,8) → results in addr order 3,2,1,0 with values 4,3,2,1, completing in 26 cycles.
- Complex forward, L[1][0]=0+1j, b=(1,0) (first two elements, rest 0) → x1 = 0−1j, i.e. imag=0xFFFF0000, real=0.
- Saturation: b0=b1=0x7FFFFFFF real, L[1][0]=−1.0 → x1 real=0x7FFFFFFF, imag=0.
- Backpressure and stale data:
  - Hold result_out_ready_i low for 5 cycles → result_o and addr stay constant and the FSM stalls.
  - A returned row with the wrong mat_row_read_addr_i is ignored, and the solve completes correctly afterwards.
- flush_i asserted during MAC of row 2 → next cycle in_ready_o=1, busy_o=0, all valids 0. A subsequent start then yields a correct full solve.
